spi_usr2_slave: RTL and testbench



---
 rtl/spi_usr2_pkg.sv | 15 +
 rtl/spi_sync.sv | 19 +
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_usr2_slave.sv | 131 +++++++++++++
 tb/tb_spi_usr2_slave.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_usr2_pkg.sv
// Shared types and constants for the user-chip-select-2 SPI register responder.
package spi_usr2_pkg;

  localparam int C_ADR_W      = 7;
  localparam int C_DATA_W     = 8;
  localparam int C_CMD_RD_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Plain N-stage synchronizer bringing an asynchronous host SPI line into the system clock domain.
module spi_sync #(
  parameter int G_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_async,
  output logic o_sync
);

  logic [G_STAGES-1:0] r_chain;

  // Left unreset on purpose: forcing a value here could fake an edge on a line that is already active.
  always_ff @(posedge i_clk) begin
    r_chain <= {r_chain[G_STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[G_STAGES-1];

endmodule

// File: rtl/spi_sync_edge.sv
// Synchronizer with registered one-clock rise/fall pulses, used for SPI SCK and CS.
module spi_sync_edge #(
  parameter int G_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic w_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  spi_sync #(
    .G_STAGES(G_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_async(i_async),
    .o_sync (w_sync)
  );

  // During reset the history follows the live level, so leaving reset mid-frame reports no edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= w_sync;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_sync;
      r_rise <= w_sync & ~r_prev;
      r_fall <= ~w_sync & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_usr2_slave.sv
// Oversampling SPI mode-0 responder: command byte (R/W flag + 7-bit address) then
// auto-incrementing byte transfers to/from an 8-bit register bus.
module spi_usr2_slave
  import spi_usr2_pkg::*;
#(
  parameter int G_SYNC_STAGES = 2
) (
  input  logic                p_in_clk,
  input  logic                p_in_rst,
  input  logic                p_in_spi_sck,
  input  logic                p_in_spi_cs_n,
  input  logic                p_in_spi_mosi,
  output logic                p_out_spi_miso,
  output logic [C_ADR_W-1:0]  p_out_reg_adr,
  output logic [C_DATA_W-1:0] p_out_reg_wdata,
  output logic                p_out_reg_wr,
  output logic                p_out_reg_rd,
  input  logic [C_DATA_W-1:0] p_in_reg_rdata,
  output logic                p_out_busy
);

  logic w_sckRise, w_sckFall, w_csRise, w_csFall, w_mosi;
  logic w_byteDone;
  state_t r_state, w_stateNext;
  logic [2:0]          r_bitCnt;
  logic [C_DATA_W-2:0] r_rxSr;
  logic [C_DATA_W-1:0] w_rxByte;
  logic [C_DATA_W-1:0] r_txSr;
  logic [C_DATA_W-1:0] r_wdata;
  logic [C_ADR_W-1:0]  r_adr;
  logic r_wr, r_rd, r_rdDly;

  spi_sync_edge #(.G_STAGES(G_SYNC_STAGES)) u_sckEdge (
    .i_clk  (p_in_clk),
    .i_rst  (p_in_rst),
    .i_async(p_in_spi_sck),
    .o_rise (w_sckRise),
    .o_fall (w_sckFall)
  );

  spi_sync_edge #(.G_STAGES(G_SYNC_STAGES)) u_csEdge (
    .i_clk  (p_in_clk),
    .i_rst  (p_in_rst),
    .i_async(p_in_spi_cs_n),
    .o_rise (w_csRise),
    .o_fall (w_csFall)
  );

  spi_sync #(.G_STAGES(G_SYNC_STAGES)) u_mosiSync (
    .i_clk  (p_in_clk),
    .i_async(p_in_spi_mosi),
    .o_sync (w_mosi)
  );

  assign w_rxByte = {r_rxSr, w_mosi};

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_byteDone  = (r_state != IDLE) && w_sckRise && !w_csRise && (r_bitCnt == 3'd7);
    case (r_state)
      IDLE:    if (w_csFall) w_stateNext = CMD;
      CMD:     if (w_byteDone) w_stateNext = w_rxByte[C_CMD_RD_BIT] ? RD_DATA : WR_DATA;
      default: ;
    endcase
    if (w_csRise) w_stateNext = IDLE;
  end

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      r_bitCnt <= '0;
      r_rxSr   <= '0;
      r_txSr   <= '1;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_rdDly  <= 1'b0;
    end else begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_rdDly <= r_rd;
      // The write strobe carries the old address; the increment lands the clock after it.
      if (r_wr) r_adr <= r_adr + C_ADR_W'(1);
      if (r_state == IDLE) begin
        if (w_csFall) r_bitCnt <= '0;
      end else if (w_sckRise && !w_csRise) begin
        r_bitCnt <= r_bitCnt + 3'd1;
        r_rxSr   <= w_rxByte[C_DATA_W-2:0];
      end
      if (w_byteDone) begin
        case (r_state)
          CMD: begin
            r_adr <= w_rxByte[C_ADR_W-1:0];
            r_rd  <= w_rxByte[C_CMD_RD_BIT];
          end
          WR_DATA: begin
            r_wr    <= 1'b1;
            r_wdata <= w_rxByte;
          end
          RD_DATA: begin
            r_adr <= r_adr + C_ADR_W'(1);
            r_rd  <= 1'b1;
          end
          default: ;
        endcase
      end
      // A fall with bit_cnt==0 follows a byte boundary, where the fresh byte is already loaded.
      if (r_rdDly) begin
        r_txSr <= p_in_reg_rdata;
      end else if (w_sckFall && (r_state == RD_DATA) && (r_bitCnt != 3'd0)) begin
        r_txSr <= {r_txSr[C_DATA_W-2:0], 1'b1};
      end
    end
  end

  assign p_out_spi_miso  = (r_state == RD_DATA) ? r_txSr[C_DATA_W-1] : 1'b1;
  assign p_out_busy      = (r_state != IDLE);
  assign p_out_reg_adr   = r_adr;
  assign p_out_reg_wdata = r_wdata;
  assign p_out_reg_wr    = r_wr;
  assign p_out_reg_rd    = r_rd;

endmodule

// File: tb/tb_spi_usr2_slave.sv
// Self-checking bench for spi_usr2_slave: a host driving SPI frames, a register-bus
// responder, and a frame-level model that predicts strobes and MISO bytes.
module tb_spi_usr2_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sckIn;
  logic       csN;
  logic       mosi;
  logic       miso;
  logic [6:0] regAdr;
  logic [7:0] regWdata;
  logic       regWr;
  logic       regRd;
  logic [7:0] regRdata;
  logic       busy;

  int testCount = 0;
  int failCount = 0;

  logic [7:0]  refMem[128];
  logic [7:0]  envMem[128];
  logic        envInit;
  logic [14:0] expWr[$];
  logic [6:0]  expRd[$];
  logic [7:0]  txData[$];
  logic [14:0] wrEntry;
  logic [7:0]  gotByte;

  spi_usr2_slave #(.G_SYNC_STAGES(2)) dut (
    .p_in_clk       (clk),
    .p_in_rst       (rst),
    .p_in_spi_sck   (sckIn),
    .p_in_spi_cs_n  (csN),
    .p_in_spi_mosi  (mosi),
    .p_out_spi_miso (miso),
    .p_out_reg_adr  (regAdr),
    .p_out_reg_wdata(regWdata),
    .p_out_reg_wr   (regWr),
    .p_out_reg_rd   (regRd),
    .p_in_reg_rdata (regRdata),
    .p_out_busy     (busy)
  );

  always #20 clk = ~clk;

  // Register file on the far side of the bus: read data appears one clock after reg_rd.
  always @(posedge clk) begin
    if (envInit) begin
      for (int i = 0; i < 128; i++) envMem[i] <= 8'(i) ^ 8'hFF;
    end else begin
      if (regWr) envMem[regAdr] <= regWdata;
      if (regRd) regRdata <= envMem[regAdr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every strobe seen on the bus must be the next one the model predicted.
  always @(negedge clk) begin
    if (regWr) begin
      checkOutput("wr_expected", 32'(expWr.size() != 0), 32'd1);
      checkOutput("wr_rd_exclusive", 32'(regRd), 32'd0);
      if (expWr.size() != 0) begin
        wrEntry = expWr.pop_front();
        checkOutput("wr_adr", 32'(regAdr), 32'(wrEntry[14:8]));
        checkOutput("wr_data", 32'(regWdata), 32'(wrEntry[7:0]));
      end
    end
    if (regRd) begin
      checkOutput("rd_expected", 32'(expRd.size() != 0), 32'd1);
      if (expRd.size() != 0) checkOutput("rd_adr", 32'(regAdr), 32'(expRd.pop_front()));
    end
  end

  task automatic sendBits(input logic [7:0] b, input int nBits, input int lo, input int hi,
                          output logic [7:0] got);
    got = 8'hFF;
    for (int i = 0; i < nBits; i++) begin
      mosi = b[7-i];
      repeat (lo) @(negedge clk);
      got = {got[6:0], miso};
      sckIn = 1'b1;
      repeat (hi) @(negedge clk);
      sckIn = 1'b0;
    end
  endtask

  // One complete frame: cmd, nFull data bytes from txData, optional partial byte, CS rise.
  task automatic applyStimulus(input logic [7:0] cmd, input int nFull, input int partialBits,
                               input int lo, input int hi);
    logic [6:0] ad;
    logic [7:0] got;
    logic [7:0] expMiso[$];
    for (int i = 0; i < nFull; i++) begin
      ad = cmd[6:0] + 7'(i);
      if (cmd[7]) begin
        expMiso.push_back(refMem[ad]);
      end else begin
        expWr.push_back({ad, txData[i]});
        refMem[ad] = txData[i];
        expMiso.push_back(8'hFF);
      end
    end
    if (cmd[7]) begin
      for (int i = 0; i <= nFull; i++) expRd.push_back(cmd[6:0] + 7'(i));
    end
    csN = 1'b0;
    repeat ($urandom_range(4, 8)) @(negedge clk);
    checkOutput("busy_in_frame", 32'(busy), 32'd1);
    sendBits(cmd, 8, lo, hi, got);
    checkOutput("cmd_miso", 32'(got), 32'hFF);
    for (int i = 0; i < nFull; i++) begin
      sendBits(txData[i], 8, lo, hi, got);
      checkOutput("data_miso", 32'(got), 32'(expMiso[i]));
    end
    if (partialBits > 0) sendBits(8'($urandom), partialBits, lo, hi, got);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    csN = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
    checkOutput("miso_after_frame", 32'(miso), 32'd1);
    checkOutput("wr_all_seen", 32'(expWr.size()), 32'd0);
    checkOutput("rd_all_seen", 32'(expRd.size()), 32'd0);
  endtask

  initial begin
    #(40 * 90000);
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    envInit = 1'b1;
    csN     = 1'b1;
    sckIn   = 1'b0;
    mosi    = 1'b0;
    for (int i = 0; i < 128; i++) refMem[i] = 8'(i) ^ 8'hFF;
    repeat (5) @(negedge clk);
    rst     = 1'b0;
    envInit = 1'b0;
    @(negedge clk);
    checkOutput("rst_miso", 32'(miso), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr", 32'(regWr), 32'd0);
    checkOutput("rst_rd", 32'(regRd), 32'd0);
    checkOutput("rst_adr", 32'(regAdr), 32'd0);
    checkOutput("rst_wdata", 32'(regWdata), 32'd0);

    // Read 3 bytes from 0x10: expect 0xEF, 0xEE, 0xED and rd at 0x10..0x13.
    txData = '{8'h00, 8'h00, 8'h00};
    applyStimulus(8'h90, 3, 0, 4, 4);

    // Write 0xA5, 0x3C from 0x05.
    txData = '{8'hA5, 8'h3C};
    applyStimulus(8'h05, 2, 0, 4, 4);

    // Address wrap 0x7F -> 0x00.
    txData = '{8'($urandom), 8'($urandom)};
    applyStimulus(8'h7F, 2, 0, 4, 4);

    // Abort after 5 data bits, then a clean write of 0x55 to 0x01.
    txData.delete();
    applyStimulus(8'h20, 0, 5, 4, 4);
    txData = '{8'h55};
    applyStimulus(8'h01, 1, 0, 4, 4);

    // Reset pulse in the middle of the second byte of a read from 0x20.
    expRd.push_back(7'h20);
    expRd.push_back(7'h21);
    csN = 1'b0;
    repeat (5) @(negedge clk);
    sendBits(8'hA0, 8, 4, 4, gotByte);
    sendBits(8'h00, 8, 4, 4, gotByte);
    checkOutput("rstmid_byte1", 32'(gotByte), 32'(refMem[7'h20]));
    sendBits(8'h00, 3, 4, 4, gotByte);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmid_miso", 32'(miso), 32'd1);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_adr", 32'(regAdr), 32'd0);
    sendBits(8'h00, 5, 4, 4, gotByte);
    sendBits(8'h5A, 8, 4, 4, gotByte);
    checkOutput("rstmid_ignored_miso", 32'(gotByte), 32'hFF);
    repeat (3) @(negedge clk);
    csN = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rstmid_busy_end", 32'(busy), 32'd0);
    checkOutput("rstmid_rd_all_seen", 32'(expRd.size()), 32'd0);

    // SCK and MOSI noise while deselected must produce nothing.
    repeat (20) begin
      sckIn = ~sckIn;
      mosi  = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    sckIn = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("noise_busy", 32'(busy), 32'd0);
    checkOutput("noise_miso", 32'(miso), 32'd1);

    // Random frames at the fastest legal SCK, random commands, lengths, aborts and gaps.
    for (int f = 0; f < 200; f++) begin
      int nFull;
      int partialBits;
      nFull       = $urandom_range(0, 2);
      partialBits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      txData.delete();
      for (int i = 0; i < nFull; i++) txData.push_back(8'($urandom));
      applyStimulus(8'($urandom), nFull, partialBits, $urandom_range(4, 5), $urandom_range(4, 5));
      repeat ($urandom_range(2, 8)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
